// File: rtl/pipelined_cla_addsub_if.sv
// Valid/ready stream bundle for the pipelined lookahead adder/subtractor.
// The master side supplies operand beats and result back-pressure; the
// slave side (the adder) answers with in_ready and the result beat.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, op_sub, sat, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, sat, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// An input register captures P/G of the effective operands, then one
// lookahead group is resolved per stage with the inter-group carry held in
// registers. Groups already resolved overwrite their P bits with sum bits,
// so each beat carries a single word that turns from P into the raw sum as
// it moves down the pipe. The last stage applies saturation and registers
// the result flags. The whole pipe stalls together under back-pressure.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int NGROUPS = WIDTH / BLOCK;
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic               advance;
    logic [WIDTH-1:0]   b_eff;
    logic               c0;

    logic [NGROUPS-1:0] vld_q;
    logic [NGROUPS-1:0] carry_q;
    logic [NGROUPS-1:0] sat_q;
    logic [NGROUPS-1:0] a_msb_q;
    logic [NGROUPS-1:0] b_msb_q;
    logic [WIDTH-1:0]   p_q [NGROUPS];
    logic [WIDTH-1:0]   g_q [NGROUPS];

    logic [WIDTH-1:0]   p_nxt [NGROUPS];
    logic [NGROUPS-1:0] c_nxt;

    logic [WIDTH-1:0]   raw_sum;
    logic [WIDTH-1:0]   final_sum;
    logic               ovf_nxt;

    logic               out_valid_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               overflow_q;
    logic               zero_q;

    // Carry into bit n of a group, written as the flat lookahead sum of
    // products: cin*P[n-1..0] | G[0]*P[n-1..1] | ... | G[n-1].
    function automatic logic la_carry(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             cin,
        input int               n
    );
        logic c;
        logic t;
        c = cin;
        for (int j = 0; j < n; j++) begin
            c = c & p[j];
        end
        for (int j = 0; j < n; j++) begin
            t = g[j];
            for (int m = j + 1; m < n; m++) begin
                t = t & p[m];
            end
            c = c | t;
        end
        return c;
    endfunction

    // Stall-all flow control plus operand conditioning for subtract.
    always_comb begin
        advance      = !(out_valid_q && !bus.out_ready);
        b_eff        = bus.op_sub ? ~bus.b : bus.b;
        c0           = bus.op_sub ? ~bus.cin : bus.cin;
        bus.in_ready = advance;
    end

    // Each stage k resolves group k from its registered carry-in.
    always_comb begin
        logic [BLOCK-1:0] pg;
        logic [BLOCK-1:0] gg;
        pg = '0;
        gg = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            p_nxt[k] = p_q[k];
            pg = p_q[k][k*BLOCK +: BLOCK];
            gg = g_q[k][k*BLOCK +: BLOCK];
            for (int i = 0; i < BLOCK; i++) begin
                p_nxt[k][k*BLOCK+i] = pg[i] ^ la_carry(pg, gg, carry_q[k], i);
            end
            c_nxt[k] = la_carry(pg, gg, carry_q[k], BLOCK);
        end
    end

    // Overflow from the operand signs and the raw sign, then optional clamp.
    always_comb begin
        raw_sum   = p_nxt[NGROUPS-1];
        ovf_nxt   = (a_msb_q[NGROUPS-1] == b_msb_q[NGROUPS-1]) &&
                    (raw_sum[WIDTH-1] != a_msb_q[NGROUPS-1]);
        final_sum = raw_sum;
        if (sat_q[NGROUPS-1] && ovf_nxt) begin
            final_sum = a_msb_q[NGROUPS-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Pipeline and output registers; everything moves only when advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            carry_q     <= '0;
            sat_q       <= '0;
            a_msb_q     <= '0;
            b_msb_q     <= '0;
            for (int k = 0; k < NGROUPS; k++) begin
                p_q[k] <= '0;
                g_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            vld_q[0]   <= bus.in_valid;
            p_q[0]     <= bus.a ^ b_eff;
            g_q[0]     <= bus.a & b_eff;
            carry_q[0] <= c0;
            sat_q[0]   <= bus.sat;
            a_msb_q[0] <= bus.a[WIDTH-1];
            b_msb_q[0] <= b_eff[WIDTH-1];
            for (int k = 1; k < NGROUPS; k++) begin
                vld_q[k]   <= vld_q[k-1];
                p_q[k]     <= p_nxt[k-1];
                g_q[k]     <= g_q[k-1];
                carry_q[k] <= c_nxt[k-1];
                sat_q[k]   <= sat_q[k-1];
                a_msb_q[k] <= a_msb_q[k-1];
                b_msb_q[k] <= b_msb_q[k-1];
            end
            out_valid_q <= vld_q[NGROUPS-1];
            sum_q       <= final_sum;
            cout_q      <= c_nxt[NGROUPS-1];
            overflow_q  <= ovf_nxt;
            zero_q      <= (final_sum == '0);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub in three shapes:
// 32/8 (depth 4), 16/4 (depth 4) and 8/8 (depth 1). Expected results come
// from a plain-integer reference model and a hand-written vector table.
module tb_pipelined_cla_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op_sub;
        logic        sat;
    } beat_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op_sub;
        logic        sat;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs [13];

    pipelined_cla_addsub_if #(.WIDTH(32)) if32 ();
    pipelined_cla_addsub_if #(.WIDTH(16)) if16 ();
    pipelined_cla_addsub_if #(.WIDTH(8))  if8  ();

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    pipelined_cla_addsub #(.WIDTH(8),  .BLOCK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference: integer add/subtract with true signed range check.
    function automatic exp_t refModel(input int w, input beat_t bt);
        longint unsigned m, ua, ub, uc, full;
        longint          sa, sb, sc, t, smax, smin;
        exp_t            r;
        m    = (64'd1 << w) - 64'd1;
        ua   = 64'(bt.a) & m;
        ub   = 64'(bt.b) & m;
        uc   = 64'(bt.cin);
        sa   = (ua > (m >> 1)) ? longint'(ua) - longint'(m) - 64'sd1 : longint'(ua);
        sb   = (ub > (m >> 1)) ? longint'(ub) - longint'(m) - 64'sd1 : longint'(ub);
        sc   = longint'(uc);
        smax = longint'(m >> 1);
        smin = -smax - 64'sd1;
        if (bt.op_sub) begin
            full   = (ua - ub - uc) & m;
            r.cout = (ua >= ub + uc);
            t      = sa - sb - sc;
        end else begin
            full   = ua + ub + uc;
            r.cout = ((full >> w) != 64'd0);
            full   = full & m;
            t      = sa + sb + sc;
        end
        r.ovf = (t > smax) || (t < smin);
        r.sum = 32'(full);
        if (bt.sat && r.ovf) begin
            r.sum = (t > smax) ? 32'(smax) : 32'(smin & longint'(m));
        end
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] randOperand(input int w);
        logic [31:0] m;
        logic [31:0] v;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       v = m >> 1;
            1:       v = ~(m >> 1);
            2:       v = m;
            3:       v = 32'd0;
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    function automatic beat_t randBeat(input int w);
        beat_t bt;
        bt.a      = randOperand(w);
        bt.b      = randOperand(w);
        bt.cin    = 1'($urandom_range(0, 1));
        bt.op_sub = 1'($urandom_range(0, 1));
        bt.sat    = 1'($urandom_range(0, 1));
        return bt;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input beat_t bt);
        if32.a        = bt.a;
        if32.b        = bt.b;
        if32.cin      = bt.cin;
        if32.op_sub   = bt.op_sub;
        if32.sat      = bt.sat;
        if32.in_valid = 1'b1;
    endtask

    task automatic idleAll();
        if32.in_valid = 1'b0; if32.out_ready = 1'b1; if32.a = '0; if32.b = '0;
        if32.cin = 1'b0; if32.op_sub = 1'b0; if32.sat = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.a = '0; if16.b = '0;
        if16.cin = 1'b0; if16.op_sub = 1'b0; if16.sat = 1'b0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b1; if8.a = '0; if8.b = '0;
        if8.cin = 1'b0; if8.op_sub = 1'b0; if8.sat = 1'b0;
    endtask

    // Reset values packed as {out_valid, sum, cout, overflow, zero, in_ready}.
    task automatic checkResetState(input string tag);
        checkOutput({tag, " dut32"}, {if32.out_valid, if32.sum, if32.cout, if32.overflow, if32.zero, if32.in_ready}, 64'h1);
        checkOutput({tag, " dut16"}, {if16.out_valid, if16.sum, if16.cout, if16.overflow, if16.zero, if16.in_ready}, 64'h1);
        checkOutput({tag, " dut8"},  {if8.out_valid,  if8.sum,  if8.cout,  if8.overflow,  if8.zero,  if8.in_ready},  64'h1);
    endtask

    // One isolated beat per vector; the result is first seen on the
    // negedge after edge N+4, which is the fifth negedge counted here.
    task automatic runDirected();
        int    lat;
        logic  got;
        beat_t bt;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bt = '{a: vecs[i].a, b: vecs[i].b, cin: vecs[i].cin, op_sub: vecs[i].op_sub, sat: vecs[i].sat};
            applyStimulus(bt);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                @(negedge clk);
                lat++;
                if32.in_valid = 1'b0;
                got = if32.out_valid;
            end
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
            checkOutput($sformatf("vec%0d sum", i),      64'(if32.sum),      64'(vecs[i].sum));
            checkOutput($sformatf("vec%0d cout", i),     64'(if32.cout),     64'(vecs[i].cout));
            checkOutput($sformatf("vec%0d overflow", i), 64'(if32.overflow), 64'(vecs[i].ovf));
            checkOutput($sformatf("vec%0d zero", i),     64'(if32.zero),     64'(vecs[i].zero));
        end
    endtask

    // Eight back-to-back beats with out_ready held low on cycles 6..8.
    task automatic runStream32();
        exp_t  q[$];
        exp_t  e;
        exp_t  held;
        beat_t cur;
        int    sent = 0;
        int    recv = 0;
        int    cyc  = 0;
        int    extra = 0;
        held = '0;
        cur  = randBeat(32);
        while (recv < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            applyStimulus(cur);
            if32.in_valid  = (sent < 8);
            if32.out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (!if32.out_ready) begin
                checkOutput($sformatf("stall%0d out_valid", cyc), 64'(if32.out_valid), 64'd1);
                checkOutput($sformatf("stall%0d in_ready", cyc),  64'(if32.in_ready),  64'd0);
                if (cyc == 6) begin
                    held = {if32.sum, if32.cout, if32.overflow, if32.zero};
                end else begin
                    checkOutput($sformatf("stall%0d hold", cyc),
                                64'({if32.sum, if32.cout, if32.overflow, if32.zero}), 64'(held));
                end
            end
            if (if32.in_valid && if32.in_ready) begin
                q.push_back(refModel(32, cur));
                sent++;
                cur = randBeat(32);
            end
            if (if32.out_valid && if32.out_ready) begin
                checkOutput("stream32 pending", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checkOutput($sformatf("stream32 beat%0d", recv),
                                64'({if32.sum, if32.cout, if32.overflow, if32.zero}), 64'(e));
                end
                recv++;
            end
        end
        if32.in_valid = 1'b0;
        checkOutput("stream32 received", 64'(recv), 64'd8);
        repeat (6) begin
            @(negedge clk);
            if (if32.out_valid) extra++;
        end
        checkOutput("stream32 no duplicates", 64'(extra), 64'd0);
    endtask

    // Random valid/ready traffic on the 16/4 and 8/8 shapes together.
    task automatic runSmall();
        exp_t  q16[$];
        exp_t  q8[$];
        exp_t  e;
        beat_t b16, b8;
        int    s16 = 0, s8 = 0, r16 = 0, r8 = 0, cyc = 0;
        b16 = randBeat(16);
        b8  = randBeat(8);
        while ((r16 < 30 || r8 < 30) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if16.a = b16.a[15:0]; if16.b = b16.b[15:0]; if16.cin = b16.cin;
            if16.op_sub = b16.op_sub; if16.sat = b16.sat;
            if16.in_valid  = (s16 < 30) && ($urandom_range(0, 3) != 0);
            if16.out_ready = ($urandom_range(0, 3) != 0);
            if8.a = b8.a[7:0]; if8.b = b8.b[7:0]; if8.cin = b8.cin;
            if8.op_sub = b8.op_sub; if8.sat = b8.sat;
            if8.in_valid  = (s8 < 30) && ($urandom_range(0, 3) != 0);
            if8.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (if16.in_valid && if16.in_ready) begin
                q16.push_back(refModel(16, b16));
                s16++;
                b16 = randBeat(16);
            end
            if (if8.in_valid && if8.in_ready) begin
                q8.push_back(refModel(8, b8));
                s8++;
                b8 = randBeat(8);
            end
            if (if16.out_valid && if16.out_ready) begin
                checkOutput("dut16 pending", 64'(q16.size() > 0), 64'd1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    checkOutput($sformatf("dut16 beat%0d", r16),
                                64'({if16.sum, if16.cout, if16.overflow, if16.zero}),
                                64'({e.sum[15:0], e.cout, e.ovf, e.zero}));
                end
                r16++;
            end
            if (if8.out_valid && if8.out_ready) begin
                checkOutput("dut8 pending", 64'(q8.size() > 0), 64'd1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    checkOutput($sformatf("dut8 beat%0d", r8),
                                64'({if8.sum, if8.cout, if8.overflow, if8.zero}),
                                64'({e.sum[7:0], e.cout, e.ovf, e.zero}));
                end
                r8++;
            end
        end
        idleAll();
        checkOutput("dut16 received", 64'(r16), 64'd30);
        checkOutput("dut8 received",  64'(r8),  64'd30);
    endtask

    // Three beats in flight everywhere, then an asynchronous reset pulse.
    task automatic runResetMid();
        beat_t bt;
        int    seen32 = 0, seen16 = 0, seen8 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bt = randBeat(32);
            applyStimulus(bt);
            bt = randBeat(16);
            if16.a = bt.a[15:0]; if16.b = bt.b[15:0]; if16.cin = bt.cin;
            if16.op_sub = bt.op_sub; if16.sat = bt.sat; if16.in_valid = 1'b1;
            bt = randBeat(8);
            if8.a = bt.a[7:0]; if8.b = bt.b[7:0]; if8.cin = bt.cin;
            if8.op_sub = bt.op_sub; if8.sat = bt.sat; if8.in_valid = 1'b1;
        end
        @(negedge clk);
        idleAll();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (if32.out_valid) seen32++;
            if (if16.out_valid) seen16++;
            if (if8.out_valid)  seen8++;
        end
        checkOutput("post-reset dut32 silent", 64'(seen32), 64'd0);
        checkOutput("post-reset dut16 silent", 64'(seen16), 64'd0);
        checkOutput("post-reset dut8 silent",  64'(seen8),  64'd0);
    endtask

    // Hard stop in case anything above stops making progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed table, stalled stream, random, reset.
    initial begin
        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0000_00FF, 1'b1, 1'b0, 1'b0};

        idleAll();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        runDirected();
        runStream32();
        runSmall();
        runResetMid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor. Splits a WIDTH-bit operation into WIDTH/BLOCK lookahead groups, resolves one group per clock, and carries the inter-group carry through registers. Supports add and subtract-with-borrow, signed overflow detection, optional signed saturation, and a zero flag. Sits in the datapath as the throughput-oriented replacement for single-cycle 32-bit lookahead adders, with a valid/ready stream on both sides.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of BLOCK.
- BLOCK, 8: lookahead group width in bits; ≥1. NGROUPS = WIDTH/BLOCK = pipeline depth.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op_sub  in  1  0: a+b+cin; 1: a−b−cin.
- sat  in  1  1: clamp to signed min/max on overflow.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result (post-saturation).
- cout  out  1  raw carry out of MSB (sub: 1 = no borrow).
- overflow  out  1  signed overflow of the unsaturated result.
- zero  out  1  sum == 0 (post-saturation).

## Operation
- Effective operand: b' = op_sub ? ~b : b; c0 = op_sub ? ~cin : cin. Result = a + b' + c0 mod 2^WIDTH.
- Within a group: P = a^b', G = a&b'; group carries via full lookahead from group carry-in; group sum = P ^ carries.
- Stage k (0..NGROUPS−1) computes group k using carry registered by stage k−1 (stage 0 uses c0); registers group sum bits and group carry-out.
- Skew: group k operands delayed k stages; completed low groups delayed to align at the output. op_sub-derived b', sat, and a/b' MSBs travel with the beat.
- overflow = (a[W−1] == b'[W−1]) & (raw_sum[W−1] != a[W−1]).
- Saturation: if sat & overflow, sum = a[W−1] ? {1,0…0} : {0,1…1}; else raw_sum. cout and overflow always reflect the raw result.
- zero computed on final sum.
- Each stage holds a valid bit; pipeline is stall-all: advance = !(out_valid & !out_ready). in_ready = advance (combinational from out_ready). Accept occurs when in_valid & in_ready.
- Bubbles propagate as invalid stages; order preserved; no beat dropped or duplicated.

## Timing
- Reset (async assert, sync release on clk): all valid bits 0, out_valid 0, sum 0, cout 0, overflow 0, zero 0, in_ready 1.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+NGROUPS (WIDTH=32, BLOCK=8: 4 cycles).
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid & !out_ready freezes every stage and all outputs; in_ready=0 same cycle. Outputs stable until handshake.
- Simultaneous accept and output handshake in one cycle is permitted; occupancy unchanged.
- Reset mid-operation: all in-flight beats discarded immediately; nothing emitted after release.
- BLOCK = WIDTH: depth 1, latency 1 cycle.

## Test plan
- Add 0xFFFFFFFF + 0x00000001, cin=0 -> 4 cycles later sum=0x00000000, cout=1, overflow=0, zero=1.
- Add 0x7FFFFFFF + 0x00000001, sat=0 -> sum=0x80000000, overflow=1; same with sat=1 -> sum=0x7FFFFFFF, overflow=1, cout=0.
- Sub 5 − 7, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0; sub 7 − 5, cin=1 -> sum=0x00000001, cout=1.
- Sub 0x80000000 − 1, sat=1 -> sum=0x80000000, overflow=1, cout=1; sat=0 -> sum=0x7FFFFFFF.
- Stream 8 back-to-back random beats, out_ready low for 3 cycles mid-stream -> in_ready low during stall, all 8 results in order, match reference model, no loss/duplication.
- 3 beats in flight, pulse rst_n low -> out_valid 0 immediately, outputs 0, no result after release; repeat with WIDTH=16, BLOCK=4 (latency 4) and WIDTH=BLOCK=8 (latency 1).
